fetch_stage: RTL and testbench

//  Instruction-fetch stage (IF) of the 5-stage pipeline, directly upstream of decode.

---
 rtl/fetch_stage_if.sv | 39 +++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode/hazard controls, instruction-memory port, IF/ID outputs.
// master = fetch stage, slave = its environment.
interface fetch_stage_if #(
    parameter int IMEM_AW = 8
);
    logic               fetch_stall;
    logic               branch_taken;
    logic [31:0]        dec_fetch_br_PC;
    logic               imem_rd_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        fetch_dec_instruction;
    logic [31:0]        fetch_dec_pc;
    logic               fetch_dec_valid;

    modport master (
        input  fetch_stall,
        input  branch_taken,
        input  dec_fetch_br_PC,
        input  imem_rdata,
        output imem_rd_en,
        output imem_addr,
        output fetch_dec_instruction,
        output fetch_dec_pc,
        output fetch_dec_valid
    );

    modport slave (
        output fetch_stall,
        output branch_taken,
        output dec_fetch_br_PC,
        output imem_rdata,
        input  imem_rd_en,
        input  imem_addr,
        input  fetch_dec_instruction,
        input  fetch_dec_pc,
        input  fetch_dec_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, synchronous imem reads, IF/ID register.
// A skid register keeps the in-flight word across a stall so release adds no bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        HOLD
    } state_t;

    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic        skid_vld_q, skid_vld_d;
    if_id_t      skid_q, skid_d;
    if_id_t      ifid_q, ifid_d;
    if_id_t      rsp_word;
    logic        stall;
    logic        take_br;

    assign stall    = bus.fetch_stall;
    assign take_br  = bus.branch_taken && ifid_q.valid && !stall;
    assign rsp_word = '{instr: bus.imem_rdata, pc: rsp_pc_q, valid: 1'b1};

    assign bus.imem_rd_en            = !rst && !stall;
    assign bus.imem_addr             = pc_q[IMEM_AW+1:2];
    assign bus.fetch_dec_instruction = ifid_q.instr;
    assign bus.fetch_dec_pc          = ifid_q.pc;
    assign bus.fetch_dec_valid       = ifid_q.valid;

    // Next-state: stall freezes and parks the in-flight word; otherwise fetch/redirect.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_pc_d   = rsp_pc_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        ifid_d     = ifid_q;
        if (stall) begin
            if (rsp_vld_q) begin
                skid_d     = rsp_word;
                skid_vld_d = 1'b1;
            end
            rsp_vld_d = 1'b0;
            state_d   = HOLD;
        end else begin
            rsp_vld_d  = 1'b1;
            rsp_pc_d   = pc_q;
            skid_vld_d = 1'b0;
            pc_d       = pc_q + 32'd4;
            unique case (state_q)
                FILL: begin
                    ifid_d  = BUBBLE;
                    state_d = RUN;
                end
                RUN: begin
                    ifid_d  = rsp_vld_q ? rsp_word : BUBBLE;
                    state_d = RUN;
                end
                HOLD: begin
                    ifid_d  = skid_vld_q ? skid_q : BUBBLE;
                    state_d = RUN;
                end
                default: begin
                    ifid_d  = BUBBLE;
                    state_d = FILL;
                end
            endcase
            // Redirect: squash the word on imem_rdata and the read issued now.
            if (take_br) begin
                pc_d      = ifid_q.pc + 32'd4 + bus.dec_fetch_br_PC;
                ifid_d    = BUBBLE;
                rsp_vld_d = 1'b0;
                state_d   = FILL;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            pc_q       <= RESET_PC;
            rsp_vld_q  <= 1'b0;
            rsp_pc_q   <= 32'h0;
            skid_vld_q <= 1'b0;
            skid_q     <= BUBBLE;
            ifid_q     <= BUBBLE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_pc_q   <= rsp_pc_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
            ifid_q     <= ifid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem word i holds 32'h1000+i.
// Instance b uses RESET_PC=0x3F8 to exercise address wrap.
module tb_fetch_stage;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    fetch_stage_if #(.IMEM_AW(8)) bus_a ();
    fetch_stage_if #(.IMEM_AW(8)) bus_b ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (8),
        .NOP_INSTR(32'h0000_0000)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    fetch_stage #(
        .RESET_PC (32'h0000_03F8),
        .IMEM_AW  (8),
        .NOP_INSTR(32'h0000_0000)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    // Clock.
    always #5 clk = ~clk;

    // Synchronous instruction memories.
    always @(posedge clk) begin
        if (bus_a.imem_rd_en) bus_a.imem_rdata <= 32'h1000 + 32'(bus_a.imem_addr);
        if (bus_b.imem_rd_en) bus_b.imem_rdata <= 32'h1000 + 32'(bus_b.imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the expected IF/ID content, compare after the edge.
    task automatic step(input logic s, input logic b, input logic [31:0] off,
                        input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        exp_t e;
        bus_a.fetch_stall     = s;
        bus_b.fetch_stall     = s;
        bus_a.branch_taken    = b;
        bus_a.dec_fetch_br_PC = off;
        sb.push_back('{ev, ei, ep});
        #1;
        chk("rd_en", 32'(bus_a.imem_rd_en), 32'(!s));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("valid", 32'(bus_a.fetch_dec_valid), 32'(e.v));
        chk("instr", bus_a.fetch_dec_instruction, e.instr);
        if (e.v) chk("pc", bus_a.fetch_dec_pc, e.pc);
    endtask

    initial begin
        rst                   = 1'b1;
        bus_a.fetch_stall     = 1'b0;
        bus_a.branch_taken    = 1'b0;
        bus_a.dec_fetch_br_PC = 32'h0;
        bus_b.fetch_stall     = 1'b0;
        bus_b.branch_taken    = 1'b0;
        bus_b.dec_fetch_br_PC = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus_a.fetch_dec_valid), 32'h0);
        chk("rst_instr", bus_a.fetch_dec_instruction, 32'h0);
        chk("rst_pc", bus_a.fetch_dec_pc, 32'h0);
        chk("rst_rd_en", 32'(bus_a.imem_rd_en), 32'h0);
        rst = 1'b0;

        // Reset release, plus address wrap on instance b.
        chk("b_addr0", 32'(bus_b.imem_addr), 32'hFE);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        chk("b_addr1", 32'(bus_b.imem_addr), 32'hFF);
        step(0, 0, 0, 1, 32'h1000, 32'h0);
        chk("b_instr0", bus_b.fetch_dec_instruction, 32'h10FE);
        chk("b_pc0", bus_b.fetch_dec_pc, 32'h3F8);
        chk("b_addr2", 32'(bus_b.imem_addr), 32'h00);
        step(0, 0, 0, 1, 32'h1001, 32'h4);
        chk("b_instr1", bus_b.fetch_dec_instruction, 32'h10FF);
        chk("b_pc1", bus_b.fetch_dec_pc, 32'h3FC);
        chk("b_addr3", 32'(bus_b.imem_addr), 32'h01);
        step(0, 0, 0, 1, 32'h1002, 32'h8);
        chk("b_instr2", bus_b.fetch_dec_instruction, 32'h1000);
        chk("b_pc2", bus_b.fetch_dec_pc, 32'h400);

        // Branch from pc 8 by +0x10; branch held during the bubble is ignored.
        step(0, 1, 32'h10, 0, 32'h0, 32'h0);
        step(0, 1, 32'h10, 0, 32'h0, 32'h0);
        step(0, 0, 0, 1, 32'h1007, 32'h1C);
        step(0, 0, 0, 1, 32'h1008, 32'h20);
        step(0, 0, 0, 1, 32'h1009, 32'h24);

        // Three-cycle stall, no gap and no duplicate on release.
        repeat (3) step(1, 0, 0, 1, 32'h1009, 32'h24);
        chk("rel_addr", 32'(bus_a.imem_addr), 32'h0B);
        step(0, 0, 0, 1, 32'h100A, 32'h28);
        step(0, 0, 0, 1, 32'h100B, 32'h2C);
        step(0, 0, 0, 1, 32'h100C, 32'h30);

        // Stall with branch: honoured only after release, skid word discarded.
        repeat (2) step(1, 1, 32'h40, 1, 32'h100C, 32'h30);
        step(0, 1, 32'h40, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 1, 32'h101D, 32'h74);
        step(0, 0, 0, 1, 32'h101E, 32'h78);

        // Reset pulse mid-stall with the skid full.
        repeat (2) step(1, 0, 0, 1, 32'h101E, 32'h78);
        rst = 1'b1;
        #1;
        chk("rst2_rd_en", 32'(bus_a.imem_rd_en), 32'h0);
        @(posedge clk);
        #1;
        chk("rst2_valid", 32'(bus_a.fetch_dec_valid), 32'h0);
        chk("rst2_instr", bus_a.fetch_dec_instruction, 32'h0);
        chk("rst2_pc", bus_a.fetch_dec_pc, 32'h0);
        chk("rst2_addr", 32'(bus_a.imem_addr), 32'h0);
        rst = 1'b0;
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 1, 32'h1000, 32'h0);
        step(0, 0, 0, 1, 32'h1001, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
